arm_fetch: RTL and testbench
============================

# arm_fetch

Instruction fetch unit for the ARM core. It is the producer side of the decoder's instruction input. It maintains the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned words are buffered in a small FIFO, and each is presented to `arm_decode` with its PC under a valid/ready handshake. Redirects from the execute stage flush the buffer and discard any in-flight response.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.

Ports:
- `clk` input, 1: the single clock; all state updates on its rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `imem_req` output, 1: fetch request; held high until `imem_ack`.
- `imem_addr` output, 32: word address of the current request; bits [1:0] always 0.
- `imem_ack` input, 1: `imem_rdata` valid this cycle; request complete. May be asserted in the same cycle as the request.
- `imem_rdata` input, 32: fetched instruction word.
- `branch_valid` input, 1: redirect, single-cycle pulse.
- `branch_target` input, 32: redirect address; bits [1:0] are ignored and forced to 0.
- `inst_valid` output, 1: `inst` and `inst_pc` hold a valid entry.
- `inst_ready` input, 1: the decoder accepts the entry this cycle.
- `inst` output, 32: instruction to the decoder (FIFO head).
- `inst_pc` output, 32: address of `inst`.

## Operation

Registers:
- `fetch_pc`: 32 bits.
- `state`: one of IDLE, REQ, DISCARD.
- FIFO storage: {inst, pc} × FIFO_DEPTH, with read/write pointers and `count` (0..FIFO_DEPTH).

Output decode:
- `imem_req` = (state == REQ) || (state == DISCARD).
- `imem_addr` = `fetch_pc` in REQ. In DISCARD it is the address of the in-flight request, which is held unchanged.
- `inst_valid` = (count != 0); `inst`/`inst_pc` = FIFO head.

Event definitions:
- pop = `inst_valid && inst_ready && !branch_valid`.
- push = state == REQ && `imem_ack` && `!branch_valid`.
- count_next = count + push − pop.

Pointers wrap modulo FIFO_DEPTH.

State transitions. Branch has priority over everything else.
- **IDLE:**
  - branch: `fetch_pc` ← target.
  - Go to REQ when count_next < FIFO_DEPTH.
- **REQ, no branch:**
  - No ack: hold `imem_addr`.
  - Ack: push {`imem_rdata`, `fetch_pc`}, then `fetch_pc` += 4. Stay in REQ if count_next < FIFO_DEPTH, else go to IDLE.
- **REQ + branch:**
  - Flush the FIFO (count ← 0, pointers ← 0). Any ack data this cycle is dropped.
  - `fetch_pc` ← target.
  - Next state is REQ if `imem_ack`, else DISCARD. The old address is latched as the in-flight address.
- **DISCARD:**
  - Hold `imem_req` at the old address until ack.
  - On ack: drop the data and go to REQ at `fetch_pc`.
  - A further branch updates `fetch_pc` (the last target wins), flushes again, and stays in DISCARD unless ack.
- Any state + branch: flush. A decoder handshake in the same cycle is void; the entry is discarded and not counted as accepted.
- `fetch_pc` arithmetic is mod 2^32; 0xFFFF_FFFC + 4 wraps to 0.

## Timing

- **Reset** (asynchronous, immediate):
  - `state`=IDLE, `fetch_pc`=RESET_PC, count=0, pointers=0, storage=0.
  - Outputs: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - Reset asserted mid-request abandons the request. Memory must tolerate a dropped req.
- **After reset release** (cycle 0 = first rising edge with `rst` low): cycle 0 IDLE; cycle 1 `imem_req`=1 at RESET_PC.
- **Zero-wait memory** (ack in the request cycle): first `inst_valid` in cycle 2; then one instruction per cycle while `inst_ready`=1.
- **N-cycle memory:** one request outstanding at a time, so throughput is 1 instruction per N cycles.
- **Push-to-valid latency:** one cycle (write, then the head is visible).
- **Branch in cycle t:**
  - `inst_valid`=0 in t+1.
  - If no request was outstanding or it was acked in t, the target is requested in t+1.
  - Otherwise the target is requested the cycle after the old ack.
- **Full FIFO:** no request is issued. After a pop, the request starts the following cycle (IDLE to REQ uses count_next).

## Test plan

- **Zero-wait memory, steady stream.** Setup: `imem_rdata` = ~`imem_addr`, `inst_ready`=1, RESET_PC=0. Required: addresses 0,4,8,…; from cycle 2, `inst`/`inst_pc` = FFFFFFFF/0, FFFFFFFB/4, … with no gaps.
- **Backpressure.** Setup: `inst_ready`=0. Required: exactly 2 entries (pc 0,4); `imem_req` drops with `fetch_pc`=8. Raise ready: pcs 0,4,8,12 in order, with none lost or duplicated.
- **Branch with a full FIFO.** Setup: branch to 0x100. Required: `inst_valid`=0 next cycle; next request at 0x100; next `inst_pc`=0x100.
- **Branch during a 3-cycle-latency request.** Setup: request at 0x8 outstanding, branch to 0x200. Required: `imem_addr` stays 0x8 until ack; that data is never presented; next request at 0x200.
- **Unaligned and back-to-back branches.** Setup: branch 0x103 alone. Required: fetch 0x100. Setup: branches 0x300 then 0x400 on consecutive cycles while in DISCARD. Required: next request at 0x400 only.
- **Asynchronous reset.** Setup: `rst` pulsed between clock edges during an outstanding request with 1 FIFO entry. Required: `imem_req`/`inst_valid` low immediately; after release, the first request is at RESET_PC in cycle 1.

Source files
------------

// File: rtl/arm_fetch.sv
// Instruction fetch unit: walks the fetch PC, issues single-outstanding imem requests,
// buffers returned words with their PC, and hands them to the decoder; redirects flush.
module arm_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_next;
    logic [31:0]      r_inflight_addr;
    logic [31:0]      w_inflight_addr_next;
    entry_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    logic [31:0]      w_target;

    assign w_target     = {branch_target[31:2], 2'b00};
    assign w_pop        = (r_count != '0) && inst_ready && !branch_valid;
    assign w_push       = (r_state == S_REQ) && imem_ack && !branch_valid;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room       = (w_count_next < CNT_W'(FIFO_DEPTH));

    assign imem_req   = (r_state == S_REQ) || (r_state == S_DISCARD);
    assign imem_addr  = (r_state == S_DISCARD) ? r_inflight_addr : r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst       = r_mem[r_rd_ptr].inst;
    assign inst_pc    = r_mem[r_rd_ptr].pc;

    // Next-state and fetch PC; a branch always wins and flushes the buffer
    always_comb begin
        w_state_next         = r_state;
        w_fetch_pc_next      = r_fetch_pc;
        w_inflight_addr_next = r_inflight_addr;
        case (r_state)
            S_IDLE: begin
                if (branch_valid) begin
                    w_fetch_pc_next = w_target;
                end
                if (branch_valid || w_room) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (branch_valid) begin
                    w_fetch_pc_next      = w_target;
                    w_inflight_addr_next = r_fetch_pc;
                    w_state_next         = imem_ack ? S_REQ : S_DISCARD;
                end else if (imem_ack) begin
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                    w_state_next    = w_room ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (branch_valid) begin
                    w_fetch_pc_next = w_target;
                end
                if (imem_ack) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_fetch_pc      <= RESET_PC;
            r_inflight_addr <= RESET_PC;
        end else begin
            r_state         <= w_state_next;
            r_fetch_pc      <= w_fetch_pc_next;
            r_inflight_addr <= w_inflight_addr_next;
        end
    end

    // Instruction buffer: circular FIFO of {inst, pc}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (branch_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{inst: imem_rdata, pc: r_fetch_pc};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_arm_fetch.sv
// Directed self-checking bench for arm_fetch with a variable-latency instruction memory model.
module tb_arm_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int mem_cnt = 0;

    arm_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory: acks the lat-th cycle of each request, data = ~address
    always @(negedge clk) begin
        if (!imem_req) begin
            mem_cnt  = 0;
            imem_ack = 1'b0;
        end else if (mem_cnt >= lat - 1) begin
            imem_ack   = 1'b1;
            imem_rdata = ~imem_addr;
            mem_cnt    = 0;
        end else begin
            imem_ack = 1'b0;
            mem_cnt++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input bit rdy);
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        inst_ready    = rdy;
        lat           = l;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        inst_ready    = 1'b0;
        lat           = 1;
        rst           = 1'b1;
        #2;
        total++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL reset_req: got %b/%h want 0/00000000", imem_req, imem_addr);
        end
        total++;
        if (inst_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", inst_valid);
        end
        total++;
        if ({inst, inst_pc} !== 64'h0) begin
            bad++; $display("FAIL reset_inst: got %h/%h want 0/0", inst, inst_pc);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL reset_cycle0_idle: got req=%b want 0", imem_req);
        end
        step;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL reset_cycle1_req: got %b/%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream;
        logic [31:0] pc;
        do_reset(1, 1'b1);
        step;
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
            bad++; $display("FAIL stream_c1: got %b/%h/%b want 1/0/0", imem_req, imem_addr, inst_valid);
        end
        for (int k = 0; k < 6; k++) begin
            step;
            pc = 32'(4 * k);
            total++;
            if ({inst_valid, inst_pc, inst, imem_addr} !== {1'b1, pc, ~pc, pc + 32'd4}) begin
                bad++;
                $display("FAIL stream_k%0d: got v=%b pc=%h inst=%h addr=%h want 1/%h/%h/%h",
                         k, inst_valid, inst_pc, inst, imem_addr, pc, ~pc, pc + 32'd4);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] pc;
        do_reset(1, 1'b0);
        step;
        step;
        total++;
        if ({imem_req, imem_addr, inst_valid, inst_pc} !== {1'b1, 32'h4, 1'b1, 32'h0}) begin
            bad++; $display("FAIL bp_c2: got %b/%h/%b/%h want 1/4/1/0", imem_req, imem_addr, inst_valid, inst_pc);
        end
        step;
        total++;
        if ({imem_req, imem_addr, inst_valid, inst_pc} !== {1'b0, 32'h8, 1'b1, 32'h0}) begin
            bad++; $display("FAIL bp_full: got %b/%h/%b/%h want 0/8/1/0", imem_req, imem_addr, inst_valid, inst_pc);
        end
        step;
        total++;
        if ({imem_req, inst_pc, inst} !== {1'b0, 32'h0, 32'hFFFF_FFFF}) begin
            bad++; $display("FAIL bp_stall: got %b/%h/%h want 0/0/ffffffff", imem_req, inst_pc, inst);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        step;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            bad++; $display("FAIL bp_resume_req: got %b/%h want 1/8", imem_req, imem_addr);
        end
        for (int k = 1; k < 4; k++) begin
            pc = 32'(4 * k);
            total++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, pc, ~pc}) begin
                bad++; $display("FAIL bp_order_%0d: got %b/%h/%h want 1/%h/%h", k, inst_valid, inst_pc, inst, pc, ~pc);
            end
            step;
        end
    endtask

    task automatic test_branch_full;
        do_reset(1, 1'b0);
        repeat (3) step;
        total++;
        if ({imem_req, inst_valid} !== 2'b01) begin
            bad++; $display("FAIL bf_setup: got req=%b valid=%b want 0/1", imem_req, inst_valid);
        end
        @(negedge clk);
        branch_valid  = 1'b1;
        branch_target = 32'h100;
        step;
        total++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            bad++; $display("FAIL bf_next: got v=%b req=%b addr=%h want 0/1/00000100", inst_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        branch_valid = 1'b0;
        inst_ready   = 1'b1;
        step;
        total++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, ~32'h100}) begin
            bad++; $display("FAIL bf_inst: got %b/%h/%h want 1/00000100/fffffeff", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_branch_latency;
        bit found = 1'b0;
        do_reset(3, 1'b1);
        for (int i = 0; i < 20 && !found; i++) begin
            step;
            if (imem_req === 1'b1 && imem_addr === 32'h8) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL bl_wait_addr8: got addr=%h want 00000008 within 20 cycles", imem_addr);
        end
        @(negedge clk);
        branch_valid  = 1'b1;
        branch_target = 32'h200;
        step;
        @(negedge clk);
        branch_valid = 1'b0;
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
            bad++; $display("FAIL bl_hold1: got %b/%h/%b want 1/8/0", imem_req, imem_addr, inst_valid);
        end
        step;
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
            bad++; $display("FAIL bl_hold2: got %b/%h/%b want 1/8/0", imem_req, imem_addr, inst_valid);
        end
        step;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h200, 1'b0}) begin
                bad++; $display("FAIL bl_target_%0d: got %b/%h/%b want 1/200/0", k, imem_req, imem_addr, inst_valid);
            end
            step;
        end
        total++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, ~32'h200}) begin
            bad++; $display("FAIL bl_inst: got %b/%h/%h want 1/00000200/fffffdff", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_unaligned_b2b;
        do_reset(1, 1'b1);
        branch_valid  = 1'b1;
        branch_target = 32'h103;
        step;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL ua_addr: got %b/%h want 1/00000100", imem_req, imem_addr);
        end
        @(negedge clk);
        branch_valid = 1'b0;
        step;
        total++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL ua_inst_pc: got %b/%h want 1/00000100", inst_valid, inst_pc);
        end

        do_reset(3, 1'b1);
        step;
        @(negedge clk);
        branch_valid  = 1'b1;
        branch_target = 32'h300;
        step;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL b2b_hold1: got %b/%h want 1/0", imem_req, imem_addr);
        end
        @(negedge clk);
        branch_target = 32'h400;
        step;
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
            bad++; $display("FAIL b2b_hold2: got %b/%h/%b want 1/0/0", imem_req, imem_addr, inst_valid);
        end
        @(negedge clk);
        branch_valid = 1'b0;
        step;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h400}) begin
                bad++; $display("FAIL b2b_target_%0d: got %b/%h want 1/00000400", k, imem_req, imem_addr);
            end
            step;
        end
        total++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h400, ~32'h400}) begin
            bad++; $display("FAIL b2b_inst: got %b/%h/%h want 1/00000400/fffffbff", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_async_reset;
        do_reset(3, 1'b0);
        repeat (4) step;
        total++;
        if ({inst_valid, inst_pc, imem_req, imem_addr} !== {1'b1, 32'h0, 1'b1, 32'h4}) begin
            bad++; $display("FAIL ar_setup: got %b/%h/%b/%h want 1/0/1/4", inst_valid, inst_pc, imem_req, imem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({imem_req, inst_valid} !== 2'b00) begin
            bad++; $display("FAIL ar_immediate: got req=%b valid=%b want 0/0", imem_req, inst_valid);
        end
        total++;
        if ({imem_addr, inst, inst_pc} !== 96'h0) begin
            bad++; $display("FAIL ar_values: got %h/%h/%h want 0/0/0", imem_addr, inst, inst_pc);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL ar_cycle0: got req=%b want 0", imem_req);
        end
        step;
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
            bad++; $display("FAIL ar_cycle1: got %b/%h/%b want 1/0/0", imem_req, imem_addr, inst_valid);
        end
    endtask

    initial begin
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        rst           = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        inst_ready    = 1'b0;
        test_reset;
        test_stream;
        test_backpressure;
        test_branch_full;
        test_branch_latency;
        test_unaligned_b2b;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
